// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared types and default sizing for the FIFO drain controller.
package fifo_drain_ctrl_pkg;

    localparam int BW_DEF    = 4;
    localparam int SIMD_DEF  = 1;
    localparam int LEN_W_DEF = 8;
    localparam int DW        = SIMD_DEF * BW_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FIN   = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_drain_ctrl_skid2.sv
// Two-entry in-order valid/ready buffer. Entry 0 is always the head.
module fifo_out_skid2
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int W = DW
) (
    input  logic         rd_clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head_data
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic [1:0]   occ_q, occ_d;

    // Next-state for entries and occupancy; a pop shifts entry 1 into the head.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (push && pop) begin
            if (occ_q == 2'd1) begin
                ent0_d = push_data;
            end else begin
                ent0_d = ent1_q;
                ent1_d = push_data;
            end
        end else if (push) begin
            if (occ_q == 2'd0) ent0_d = push_data;
            else               ent1_d = push_data;
            occ_d = occ_q + 2'd1;
        end else if (pop) begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
        end
    end

    // Storage register with synchronous clear.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = ent0_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side burst controller: pops len words from the FIFO into a 2-entry
// buffer and streams them out on valid/ready.
//
// state | meaning
// IDLE  | waiting for start; count holds last burst result
// DRAIN | reading FIFO until all words delivered downstream
// FIN   | one-cycle done pulse
module fifo_drain_ctrl
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int bw    = BW_DEF,
    parameter int simd  = SIMD_DEF,
    parameter int len_w = LEN_W_DEF
) (
    input  logic                 rd_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [len_w-1:0]     len,
    input  logic                 fifo_empty,
    input  logic [simd*bw-1:0]   fifo_out,
    output logic                 fifo_rd,
    output logic [simd*bw-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [len_w-1:0]     count
);

    localparam int DATA_W = simd * bw;

    state_e           state_q, state_d;
    logic [len_w-1:0] rem_q, rem_d;
    logic [len_w-1:0] cnt_q, cnt_d;
    logic [len_w-1:0] len_q, len_d;
    logic [1:0]       occ;
    logic             accept;

    assign out_valid = (occ != 2'd0);
    assign accept    = out_valid && out_ready;
    assign count     = cnt_q;

    // State register.
    always_ff @(posedge rd_clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; DRAIN exit uses registered remaining/occupancy only.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len != '0) ? DRAIN : FIN;
            DRAIN:   if (rem_q == '0 && occ == 2'd0) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; fifo_rd never depends on out_ready so there is no ready->rd path.
    always_comb begin
        fifo_rd = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            DRAIN: begin
                busy    = 1'b1;
                fifo_rd = (rem_q != '0) && !fifo_empty && (occ != 2'd2);
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Burst counters: remaining words to pop and saturating delivered count.
    always_comb begin
        rem_d = rem_q;
        cnt_d = cnt_q;
        len_d = len_q;
        if (state_q == IDLE && start) begin
            rem_d = len;
            cnt_d = '0;
            len_d = len;
        end else begin
            if (fifo_rd) rem_d = rem_q - 1'b1;
            if (accept && cnt_q != len_q) cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            rem_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    fifo_out_skid2 #(.W(DATA_W)) u_skid (
        .rd_clk    (rd_clk),
        .reset     (reset),
        .push      (fifo_rd),
        .push_data (fifo_out),
        .pop       (accept),
        .occ       (occ),
        .head_data (out_data)
    );

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FIFO model, delivery scoreboard,
// a cycle table for the basic burst and hand-written corner sequences.
module tb_fifo_drain_ctrl;
    import fifo_drain_ctrl_pkg::*;

    logic          rd_clk = 1'b0;
    logic          reset, start, fifo_empty, fifo_rd, out_valid, out_ready, busy, done;
    logic [7:0]    len, count;
    logic [DW-1:0] fifo_out, out_data;

    fifo_drain_ctrl dut (
        .rd_clk(rd_clk), .reset(reset), .start(start), .len(len),
        .fifo_empty(fifo_empty), .fifo_out(fifo_out), .fifo_rd(fifo_rd),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .count(count)
    );

    always #5 rd_clk = ~rd_clk;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int acc_cnt = 0;
    int done_cnt = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic upd();
        fifo_empty = (fq.size() == 0);
        fifo_out   = (fq.size() == 0) ? '0 : fq[0];
    endtask

    task automatic fpush(input logic [DW-1:0] d, input bit expected);
        fq.push_back(d);
        if (expected) exp_q.push_back(d);
        upd();
    endtask

    task automatic flush();
        fq.delete();
        exp_q.delete();
        upd();
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #2;
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge rd_clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL %s: done not seen within %0d cycles", nm, budget);
        end
    endtask

    // FIFO model: pops when the controller's rd is high at the edge.
    always @(posedge rd_clk) begin
        automatic logic pop_now = fifo_rd;
        #1;
        if (pop_now && fq.size() > 0) void'(fq.pop_front());
        upd();
    end

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge rd_clk) begin
        if (fifo_rd) begin
            rd_cnt++;
            chk("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
        end
        if (done) done_cnt++;
        if (!reset && out_valid && out_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL sb_extra: got %0h expected nothing", out_data);
            end else begin
                chk("sb_data", {28'd0, out_data}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic          st;
        logic [7:0]    ln;
        logic          rd;
        logic          vld;
        logic          chk_data;
        logic [DW-1:0] data;
        logic          bsy;
        logic          dn;
        logic [7:0]    cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int rd0, acc0, dn0;
        bit hit;

        tbl[0] = '{1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0, 8'd0};
        tbl[3] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 8'd1};
        tbl[4] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 8'd2};
        tbl[5] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 8'd3};
        tbl[6] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 8'd4};
        tbl[7] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 8'd5};
        tbl[8] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 8'd5};
        tbl[9] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd5};

        reset = 1'b1; start = 1'b0; len = '0; out_ready = 1'b1;
        upd();
        tick();
        tick();
        reset = 1'b0;
        @(negedge rd_clk);
        chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_count", {24'd0, count}, 32'd0);
        tick();

        // Basic burst of 5 preloaded words, checked cycle by cycle.
        for (int i = 1; i <= 5; i++) fpush(DW'(i), 1'b1);
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].st;
            len   = tbl[i].ln;
            @(negedge rd_clk);
            chk($sformatf("t1_rd[%0d]", i), {31'd0, fifo_rd}, {31'd0, tbl[i].rd});
            chk($sformatf("t1_valid[%0d]", i), {31'd0, out_valid}, {31'd0, tbl[i].vld});
            if (tbl[i].chk_data)
                chk($sformatf("t1_data[%0d]", i), {28'd0, out_data}, {28'd0, tbl[i].data});
            chk($sformatf("t1_busy[%0d]", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
            chk($sformatf("t1_done[%0d]", i), {31'd0, done}, {31'd0, tbl[i].dn});
            chk($sformatf("t1_count[%0d]", i), {24'd0, count}, {24'd0, tbl[i].cnt});
            tick();
        end

        // Empty FIFO, words trickle in four cycles apart.
        acc0 = acc_cnt;
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 4; c++) tick();
            fpush(DW'(4'hA + w), 1'b1);
        end
        wait_done(40, "t2_done");
        chk("t2_accepts_at_done", acc_cnt - acc0, 32'd3);
        chk("t2_count", {24'd0, count}, 32'd3);
        tick();

        // Backpressure: exactly two pops while out_ready is low.
        for (int i = 0; i < 8; i++) fpush(DW'(8 + i), 1'b1);
        out_ready = 1'b0;
        rd0 = rd_cnt; acc0 = acc_cnt;
        start = 1'b1; len = 8'd8;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        chk("t3_stall_pops", rd_cnt - rd0, 32'd2);
        chk("t3_stall_rd", {31'd0, fifo_rd}, 32'd0);
        chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_done(40, "t3_done");
        chk("t3_pops", rd_cnt - rd0, 32'd8);
        chk("t3_accepts", acc_cnt - acc0, 32'd8);
        chk("t3_sb_empty", exp_q.size(), 32'd0);
        chk("t3_count", {24'd0, count}, 32'd8);
        tick();

        // Zero-length burst: immediate done, no reads.
        fpush(4'h7, 1'b0);
        rd0 = rd_cnt;
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        @(negedge rd_clk);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        chk("t4_count", {24'd0, count}, 32'd0);
        tick();
        @(negedge rd_clk);
        chk("t4_done_once", {31'd0, done}, 32'd0);
        chk("t4_no_reads", rd_cnt - rd0, 32'd0);
        flush();
        tick();

        // Reset on the third pop of a 6-word burst.
        for (int i = 0; i < 6; i++) fpush(DW'(i + 2), 1'b1);
        rd0 = rd_cnt; dn0 = done_cnt; hit = 0;
        start = 1'b1; len = 8'd6;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (fifo_rd && (rd_cnt - rd0) == 2) begin
                reset = 1'b1;
                hit = 1;
                break;
            end
            tick();
        end
        chk("t5_third_pop_seen", {31'd0, hit}, 32'd1);
        tick();
        reset = 1'b0;
        @(negedge rd_clk);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("t5_count", {24'd0, count}, 32'd0);
        for (int c = 0; c < 4; c++) tick();
        chk("t5_no_done", done_cnt - dn0, 32'd0);
        flush();

        // Start during DRAIN is ignored.
        for (int i = 0; i < 6; i++) fpush(DW'(i + 3), i < 4);
        rd0 = rd_cnt; acc0 = acc_cnt;
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; len = 8'd9;
        tick();
        start = 1'b0;
        wait_done(30, "t6_done");
        chk("t6_pops", rd_cnt - rd0, 32'd4);
        chk("t6_accepts", acc_cnt - acc0, 32'd4);
        chk("t6_count", {24'd0, count}, 32'd4);
        tick();
        tick();
        chk("t6_idle", {31'd0, busy}, 32'd0);
        flush();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
